crossbar_allocator: RTL and testbench
=====================================

CROSSBAR_ALLOCATOR -- requirements
Module: crossbar_allocator

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of crossbar inputs (requesters).
REQ-002 SHALL have parameter NUM_OUT, default 4, number of crossbar outputs (resources).
REQ-003 SHALL derive SELECT_SIZE = $clog2(NUM_IN) + (NUM_IN == 1) and DEST_SIZE = $clog2(NUM_OUT) + (NUM_OUT == 1).
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  [NUM_IN]  input i holds a flit for the output in req_dest[i].
REQ-007 SHALL have port req_dest  input  [NUM_IN][DEST_SIZE]  requested output per input; stable while req_valid is high.
REQ-008 SHALL have port req_last  input  [NUM_IN]  current flit of input i is the packet tail.
REQ-009 SHALL have port out_ready  input  [NUM_OUT]  downstream of output o accepts a flit this cycle.
REQ-010 SHALL have port grant  output  [NUM_IN]  flit of input i transfers this cycle; input pops it.
REQ-011 SHALL have port sel  output  [NUM_OUT][SELECT_SIZE]  drives the crossbar select lines.
REQ-012 SHALL have port enable  output  [NUM_OUT]  drives the crossbar output enables.

Function
REQ-013 SHALL keep per output o: state {IDLE, BUSY}, owner[o] (SELECT_SIZE), rr_ptr[o] (SELECT_SIZE).
REQ-014 In IDLE, output o SHALL arbitrate among inputs i with req_valid[i] && req_dest[i]==o && input i not owning any output, round-robin starting at rr_ptr[o], wrapping NUM_IN-1 -> 0.
REQ-015 On a winner w, output o SHALL register owner[o]=w and enter BUSY at the next edge; no flit transfers in the arbitration cycle (1-cycle allocation latency).
REQ-016 An input SHALL own at most one output; an input winning at two outputs in one cycle is impossible since req_dest is single-valued.
REQ-017 sel[o] SHALL equal owner[o] in BUSY and rr_ptr[o] in IDLE.
REQ-018 enable[o] SHALL be combinational: BUSY && req_valid[owner[o]] && out_ready[o].
REQ-019 grant[i] SHALL equal enable[o] for the output o owned by i, else 0.
REQ-020 While BUSY, an invalid req_valid or low out_ready SHALL stall the transfer (enable 0) without releasing ownership.
REQ-021 A transfer with req_last[owner] high SHALL return output o to IDLE at that edge and set rr_ptr[o] = owner+1 modulo NUM_IN.
REQ-022 An output released at edge N SHALL re-arbitrate in cycle N+1 (one idle bubble between packets); the releasing input re-competes at lowest priority.
REQ-023 Outputs SHALL arbitrate independently and simultaneously; up to min(NUM_IN,NUM_OUT) transfers per cycle.
REQ-024 A single-flit packet (req_last high on first flit) SHALL occupy exactly 2 cycles: allocate, transfer.
REQ-025 req_dest values >= NUM_OUT SHALL be ignored (never granted).

Reset
REQ-026 On nRST low, asynchronously: all states IDLE, owner=0, rr_ptr=0; hence grant=0, enable=0, sel=0.
REQ-027 Reset asserted mid-packet SHALL drop ownership; after release, allocation restarts from rr_ptr=0 with no stale grant.

Verification
REQ-028 Single request: input 2 -> output 1, 3 flits, out_ready=1 -> cycle 1 allocate, grant[2]/enable[1] high cycles 2-4, sel[1]=2, output 1 IDLE at cycle 5.
REQ-029 Contention: inputs 0,1,3 all -> output 2, 1-flit packets, held valid -> granted order 0,1,3,0 with 1 bubble between each.
REQ-030 Parallel: inputs 0->3, 1->2, 2->1, 3->0 simultaneously -> all four enables high in the same cycle after 1-cycle allocation.
REQ-031 Backpressure: input 1 owns output 0, out_ready[0]=0 for 3 cycles mid-packet -> enable[0]=grant[1]=0, owner holds, transfer resumes when out_ready returns.
REQ-032 Reset mid-packet: nRST low during BUSY -> grant, enable, sel zero immediately; after release a fresh request is allocated normally.
REQ-033 Out-of-range dest: NUM_OUT=3, req_dest=3 -> no grant, no enable ever.

Source files
------------

// File: rtl/crossbar_allocator.sv
// Per-output packet allocator for an NUM_IN x NUM_OUT crossbar: round-robin
// arbitration per output, wormhole ownership until the tail flit transfers.
module crossbar_allocator #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    localparam int SELECT_SIZE = $clog2(NUM_IN) + (NUM_IN == 1),
    localparam int DEST_SIZE   = $clog2(NUM_OUT) + (NUM_OUT == 1)
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic [NUM_IN-1:0]                      req_valid,
    input  logic [NUM_IN-1:0][DEST_SIZE-1:0]       req_dest,
    input  logic [NUM_IN-1:0]                      req_last,
    input  logic [NUM_OUT-1:0]                     out_ready,
    output logic [NUM_IN-1:0]                      grant,
    output logic [NUM_OUT-1:0][SELECT_SIZE-1:0]    sel,
    output logic [NUM_OUT-1:0]                     enable
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_r   [NUM_OUT];
    state_t                 state_n_s [NUM_OUT];
    logic [SELECT_SIZE-1:0] owner_r   [NUM_OUT];
    logic [SELECT_SIZE-1:0] owner_n_s [NUM_OUT];
    logic [SELECT_SIZE-1:0] rr_ptr_r  [NUM_OUT];
    logic [SELECT_SIZE-1:0] rr_ptr_n_s[NUM_OUT];

    logic [NUM_OUT-1:0]     busy_s;
    logic [NUM_IN-1:0]      owns_any_s;
    logic [NUM_OUT-1:0]     owner_valid_s;
    logic [NUM_OUT-1:0]     owner_last_s;
    logic [NUM_IN-1:0]      cand_s    [NUM_OUT];
    logic [NUM_OUT-1:0]     hi_found_s;
    logic [SELECT_SIZE-1:0] hi_idx_s  [NUM_OUT];
    logic [SELECT_SIZE-1:0] lo_idx_s  [NUM_OUT];
    logic [NUM_OUT-1:0]     win_found_s;
    logic [SELECT_SIZE-1:0] win_idx_s [NUM_OUT];

    function automatic logic [SELECT_SIZE-1:0] next_ptr(input logic [SELECT_SIZE-1:0] p);
        next_ptr = (p == SELECT_SIZE'(NUM_IN - 1)) ? SELECT_SIZE'(0) : p + SELECT_SIZE'(1);
    endfunction

    // Busy flags and select lines straight from the per-output registers
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            busy_s[o] = (state_r[o] == BUSY);
            sel[o]    = busy_s[o] ? owner_r[o] : rr_ptr_r[o];
        end
    end

    // Which inputs hold an output, and the owner's valid/last seen by each output
    always_comb begin
        owns_any_s    = {NUM_IN{1'b0}};
        owner_valid_s = {NUM_OUT{1'b0}};
        owner_last_s  = {NUM_OUT{1'b0}};
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                owns_any_s[i]    = owns_any_s[i] | (busy_s[o] & (owner_r[o] == SELECT_SIZE'(i)));
                owner_valid_s[o] = owner_valid_s[o] |
                                   (busy_s[o] & (owner_r[o] == SELECT_SIZE'(i)) & req_valid[i]);
                owner_last_s[o]  = owner_last_s[o] |
                                   (busy_s[o] & (owner_r[o] == SELECT_SIZE'(i)) & req_last[i]);
            end
        end
    end

    // Transfer enables per output
    always_comb begin
        enable = busy_s & owner_valid_s & out_ready;
    end

    // Each input is granted by the output it owns
    always_comb begin
        grant = {NUM_IN{1'b0}};
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                grant[i] = grant[i] | (enable[o] & (owner_r[o] == SELECT_SIZE'(i)));
            end
        end
    end

    // Eligible requesters per output; out-of-range destinations never match any o
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cand_s[o][i] = req_valid[i] & (req_dest[i] == DEST_SIZE'(o)) & ~owns_any_s[i];
            end
        end
    end

    // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            hi_found_s[o] = 1'b0;
            hi_idx_s[o]   = SELECT_SIZE'(0);
            lo_idx_s[o]   = SELECT_SIZE'(0);
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                lo_idx_s[o]   = cand_s[o][i] ? SELECT_SIZE'(i) : lo_idx_s[o];
                hi_idx_s[o]   = (cand_s[o][i] && (SELECT_SIZE'(i) >= rr_ptr_r[o])) ?
                                SELECT_SIZE'(i) : hi_idx_s[o];
                hi_found_s[o] = hi_found_s[o] | (cand_s[o][i] & (SELECT_SIZE'(i) >= rr_ptr_r[o]));
            end
            win_found_s[o] = |cand_s[o];
            win_idx_s[o]   = hi_found_s[o] ? hi_idx_s[o] : lo_idx_s[o];
        end
    end

    // Per-output next state: allocate in IDLE, release on tail transfer in BUSY
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            state_n_s[o]  = state_r[o];
            owner_n_s[o]  = owner_r[o];
            rr_ptr_n_s[o] = rr_ptr_r[o];
            case (state_r[o])
                IDLE: begin
                    if (win_found_s[o]) begin
                        state_n_s[o] = BUSY;
                        owner_n_s[o] = win_idx_s[o];
                    end else begin
                        state_n_s[o] = IDLE;
                    end
                end
                BUSY: begin
                    if (enable[o] && owner_last_s[o]) begin
                        state_n_s[o]  = IDLE;
                        rr_ptr_n_s[o] = next_ptr(owner_r[o]);
                    end else begin
                        state_n_s[o] = BUSY;
                    end
                end
                default: begin
                    state_n_s[o] = IDLE;
                end
            endcase
        end
    end

    // State, owner and round-robin pointer registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_r[o]  <= IDLE;
                owner_r[o]  <= SELECT_SIZE'(0);
                rr_ptr_r[o] <= SELECT_SIZE'(0);
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_r[o]  <= state_n_s[o];
                owner_r[o]  <= owner_n_s[o];
                rr_ptr_r[o] <= rr_ptr_n_s[o];
            end
        end
    end

endmodule

// File: tb/tb_crossbar_allocator.sv
// Directed bench for crossbar_allocator: 4x4 instance for the main scenarios
// and a 4x3 instance for out-of-range destinations.
module tb_crossbar_allocator;

    logic            CLK;
    logic            nRST;
    logic [3:0]      req_valid;
    logic [3:0][1:0] req_dest;
    logic [3:0]      req_last;
    logic [3:0]      out_ready;
    logic [3:0]      grant;
    logic [3:0][1:0] sel;
    logic [3:0]      enable;

    logic [3:0]      b_valid;
    logic [3:0][1:0] b_dest;
    logic [3:0]      b_last;
    logic [2:0]      b_ready;
    logic [3:0]      b_grant;
    logic [2:0][1:0] b_sel;
    logic [2:0]      b_enable;

    int errors = 0;
    int checks = 0;

    crossbar_allocator #(.NUM_IN(4), .NUM_OUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_dest(req_dest),
        .req_last(req_last), .out_ready(out_ready), .grant(grant), .sel(sel),
        .enable(enable)
    );

    crossbar_allocator #(.NUM_IN(4), .NUM_OUT(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .req_valid(b_valid), .req_dest(b_dest),
        .req_last(b_last), .out_ready(b_ready), .grant(b_grant), .sel(b_sel),
        .enable(b_enable)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 4'h0; req_dest = 8'h00; req_last = 4'h0; out_ready = 4'hF;
        b_valid = 4'h0; b_dest = 8'h00; b_last = 4'h0; b_ready = 3'b111;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        clear_inputs();
        nRST = 1'b0;
        #3;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        req_valid = 4'hF;
        req_last  = 4'hF;
        #2;
        checks++;
        if (grant !== 4'h0 || enable !== 4'h0) begin
            errors++; $display("FAIL reset_outputs: grant=%b enable=%b, expected 0000/0000", grant, enable);
        end
        checks++;
        if (sel !== 8'h00 || b_sel !== 6'h00) begin
            errors++; $display("FAIL reset_sel: sel=%h b_sel=%h, expected 00/00", sel, b_sel);
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (grant !== 4'h0 || b_grant !== 4'h0) begin
            errors++; $display("FAIL reset_held: grant=%b b_grant=%b, expected 0000", grant, b_grant);
        end
        clear_inputs();
        nRST = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        tick();
        req_valid[2] = 1'b1; req_dest[2] = 2'd1;
        #2;
        checks++;
        if (grant !== 4'h0 || enable !== 4'h0) begin
            errors++; $display("FAIL single_alloc: grant=%b enable=%b, expected 0000/0000", grant, enable);
        end
        tick();
        for (int f = 0; f < 3; f++) begin
            req_last[2] = (f == 2);
            #2;
            checks++;
            if (grant !== 4'b0100 || enable !== 4'b0010 || sel[1] !== 2'd2) begin
                errors++; $display("FAIL single_flit%0d: grant=%b enable=%b sel1=%0d, expected 0100/0010/2",
                                   f, grant, enable, sel[1]);
            end
            tick();
        end
        req_valid = 4'h0; req_last = 4'h0;
        #2;
        checks++;
        if (enable !== 4'h0 || sel[1] !== 2'd3) begin
            errors++; $display("FAIL single_idle: enable=%b sel1=%0d, expected 0000/3", enable, sel[1]);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [8];
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        tick();
        req_valid = 4'b1011; req_last = 4'b1011;
        req_dest[0] = 2'd2; req_dest[1] = 2'd2; req_dest[3] = 2'd2;
        for (int c = 0; c < 8; c++) begin
            #2;
            checks++;
            if (grant !== exp_g[c] || enable !== ((exp_g[c] != 4'h0) ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL contention_c%0d: grant=%b enable=%b, expected grant %b",
                                   c + 1, grant, enable, exp_g[c]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_parallel();
        do_reset();
        tick();
        req_valid = 4'hF; req_last = 4'hF;
        req_dest  = {2'd0, 2'd1, 2'd2, 2'd3};
        #2;
        checks++;
        if (enable !== 4'h0 || grant !== 4'h0) begin
            errors++; $display("FAIL parallel_alloc: enable=%b grant=%b, expected 0000/0000", enable, grant);
        end
        tick();
        #2;
        checks++;
        if (enable !== 4'hF || grant !== 4'hF || sel !== 8'h1B) begin
            errors++; $display("FAIL parallel_xfer: enable=%b grant=%b sel=%h, expected 1111/1111/1b",
                               enable, grant, sel);
        end
        tick();
        req_valid = 4'h0;
        #2;
        checks++;
        if (enable !== 4'h0 || sel !== 8'h6C) begin
            errors++; $display("FAIL parallel_rr: enable=%b sel=%h, expected 0000/6c", enable, sel);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        req_valid[1] = 1'b1; req_dest[1] = 2'd0;
        #2;
        checks++;
        if (grant !== 4'h0) begin
            errors++; $display("FAIL bp_alloc: grant=%b, expected 0000", grant);
        end
        tick();
        #2;
        checks++;
        if (grant !== 4'b0010 || enable !== 4'b0001) begin
            errors++; $display("FAIL bp_flit0: grant=%b enable=%b, expected 0010/0001", grant, enable);
        end
        tick();
        out_ready[0] = 1'b0;
        req_valid[3] = 1'b1; req_dest[3] = 2'd0; req_last[3] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2;
            checks++;
            if (grant !== 4'h0 || enable !== 4'h0 || sel[0] !== 2'd1) begin
                errors++; $display("FAIL bp_stall%0d: grant=%b enable=%b sel0=%0d, expected 0000/0000/1",
                                   s, grant, enable, sel[0]);
            end
            tick();
        end
        out_ready[0] = 1'b1;
        #2;
        checks++;
        if (grant !== 4'b0010 || enable !== 4'b0001) begin
            errors++; $display("FAIL bp_resume: grant=%b enable=%b, expected 0010/0001", grant, enable);
        end
        tick();
        req_last[1] = 1'b1;
        #2;
        checks++;
        if (grant !== 4'b0010 || enable !== 4'b0001) begin
            errors++; $display("FAIL bp_tail: grant=%b enable=%b, expected 0010/0001", grant, enable);
        end
        tick();
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
        #2;
        checks++;
        if (grant !== 4'h0 || sel[0] !== 2'd2) begin
            errors++; $display("FAIL bp_bubble: grant=%b sel0=%0d, expected 0000/2", grant, sel[0]);
        end
        tick();
        #2;
        checks++;
        if (grant !== 4'b1000 || enable !== 4'b0001 || sel[0] !== 2'd3) begin
            errors++; $display("FAIL bp_next_owner: grant=%b enable=%b sel0=%0d, expected 1000/0001/3",
                               grant, enable, sel[0]);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        req_valid[2] = 1'b1; req_dest[2] = 2'd1;
        tick();
        #2;
        checks++;
        if (grant !== 4'b0100) begin
            errors++; $display("FAIL rmid_busy: grant=%b, expected 0100", grant);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (grant !== 4'h0 || enable !== 4'h0 || sel !== 8'h00) begin
            errors++; $display("FAIL rmid_async: grant=%b enable=%b sel=%h, expected 0000/0000/00",
                               grant, enable, sel);
        end
        tick();
        nRST = 1'b1;
        req_valid = 4'b1000; req_dest[3] = 2'd0; req_last[3] = 1'b1;
        #2;
        checks++;
        if (grant !== 4'h0 || enable !== 4'h0 || sel !== 8'h00) begin
            errors++; $display("FAIL rmid_realloc: grant=%b enable=%b sel=%h, expected 0000/0000/00",
                               grant, enable, sel);
        end
        tick();
        #2;
        checks++;
        if (grant !== 4'b1000 || enable !== 4'b0001 || sel[0] !== 2'd3) begin
            errors++; $display("FAIL rmid_fresh: grant=%b enable=%b sel0=%0d, expected 1000/0001/3",
                               grant, enable, sel[0]);
        end
        clear_inputs();
    endtask

    task automatic test_out_of_range();
        do_reset();
        tick();
        b_valid[0] = 1'b1; b_dest[0] = 2'd3; b_last[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++;
            if (b_grant !== 4'h0 || b_enable !== 3'b000) begin
                errors++; $display("FAIL oor_c%0d: grant=%b enable=%b, expected 0000/000", c, b_grant, b_enable);
            end
            tick();
        end
        b_valid[1] = 1'b1; b_dest[1] = 2'd0; b_last[1] = 1'b1;
        #2;
        checks++;
        if (b_grant !== 4'h0) begin
            errors++; $display("FAIL oor_alloc: grant=%b, expected 0000", b_grant);
        end
        tick();
        #2;
        checks++;
        if (b_grant !== 4'b0010 || b_enable !== 3'b001) begin
            errors++; $display("FAIL oor_legal: grant=%b enable=%b, expected 0010/001", b_grant, b_enable);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
